// File: rtl/line_mem_responder.sv
// Line-oriented backing memory: accepts one 16-byte line request, waits LATENCY
// cycles, then streams four refill beats out or absorbs four writeback beats in.
module line_mem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        rd_last,
    output logic        busy
);
    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam int LINE_W  = ADDR_WIDTH - 2;
    localparam bit HAS_LAT = (LATENCY > 0);
    localparam int LAT_MAX = HAS_LAT ? LATENCY - 1 : 0;
    localparam int LAT_W   = (LAT_MAX > 0) ? $clog2(LAT_MAX + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LAT, S_READ, S_WRITE} state_t;

    state_t              state, state_nxt;
    logic [LINE_W-1:0]   line_q;
    logic                we_q;
    logic [1:0]          beat;
    logic [LAT_W-1:0]    lat_cnt;
    logic                accept, wr_fire, beat_adv;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                unused_addr_bits;

    // NOTE: storage has no reset; contents must survive rst, and a reset port on a
    // large array would prevent it from mapping onto RAM.
    logic [31:0] mem [DEPTH] = '{default: '0};

    assign word_idx         = {line_q, beat};
    assign unused_addr_bits = ^{req_addr[31:ADDR_WIDTH+2], req_addr[3:0]};

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        wr_fire   = 1'b0;
        beat_adv  = 1'b0;
        req_ready = 1'b0;
        wr_ready  = 1'b0;
        rd_valid  = 1'b0;
        rd_last   = 1'b0;
        rd_data   = '0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (HAS_LAT) state_nxt = S_LAT;
                    else         state_nxt = req_we ? S_WRITE : S_READ;
                end
            end
            S_LAT: begin
                if (lat_cnt == LAT_W'(LAT_MAX)) state_nxt = we_q ? S_WRITE : S_READ;
            end
            S_READ: begin
                rd_valid = 1'b1;
                rd_data  = mem[word_idx];
                rd_last  = (beat == 2'd3);
                beat_adv = 1'b1;
                if (beat == 2'd3) state_nxt = S_IDLE;
            end
            S_WRITE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    wr_fire  = 1'b1;
                    beat_adv = 1'b1;
                    if (beat == 2'd3) state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // Reset silences the whole interface, including any write already in flight.
        if (rst) begin
            accept    = 1'b0;
            wr_fire   = 1'b0;
            beat_adv  = 1'b0;
            req_ready = 1'b0;
            wr_ready  = 1'b0;
            rd_valid  = 1'b0;
            rd_last   = 1'b0;
            rd_data   = '0;
            busy      = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            line_q  <= '0;
            we_q    <= 1'b0;
            beat    <= '0;
            lat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                line_q  <= req_addr[ADDR_WIDTH+1:4];
                we_q    <= req_we;
                beat    <= '0;
                lat_cnt <= '0;
            end
            if (state == S_LAT) lat_cnt <= lat_cnt + LAT_W'(1);
            if (beat_adv)       beat    <= beat + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[word_idx] <= wr_data;
    end
endmodule

// File: tb/tb_line_mem_responder.sv
// Scoreboard bench for line_mem_responder: one instance with LATENCY=4 and one
// with LATENCY=0 share the stimulus; sel picks which one is observed.
module tb_line_mem_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid, req_we, wr_valid;
    logic [31:0] req_addr, wr_data;
    logic        req_ready0, wr_ready0, rd_valid0, rd_last0, busy0;
    logic        req_ready1, wr_ready1, rd_valid1, rd_last1, busy1;
    logic [31:0] rd_data0, rd_data1;

    line_mem_responder #(.ADDR_WIDTH(12), .LATENCY(4)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0),
        .req_we(req_we), .req_addr(req_addr), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready0), .rd_data(rd_data0), .rd_valid(rd_valid0),
        .rd_last(rd_last0), .busy(busy0)
    );

    line_mem_responder #(.ADDR_WIDTH(12), .LATENCY(0)) u_dut_l0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
        .req_we(req_we), .req_addr(req_addr), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready1), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .rd_last(rd_last1), .busy(busy1)
    );

    logic sel;
    int   lat;
    logic        req_ready_s, wr_ready_s, rd_valid_s, rd_last_s, busy_s;
    logic [31:0] rd_data_s;
    assign req_ready_s = sel ? req_ready1 : req_ready0;
    assign wr_ready_s  = sel ? wr_ready1  : wr_ready0;
    assign rd_valid_s  = sel ? rd_valid1  : rd_valid0;
    assign rd_last_s   = sel ? rd_last1   : rd_last0;
    assign busy_s      = sel ? busy1      : busy0;
    assign rd_data_s   = sel ? rd_data1   : rd_data0;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t       sb[$];
    beat_t       mon_e;
    logic [31:0] model_mem [4096];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] addr, input int b);
        logic [11:0] base;
        base = {addr[13:4], 2'b00};
        return int'(base) + b;
    endfunction

    task automatic push_read(input logic [31:0] addr);
        for (int b = 0; b < 4; b++)
            sb.push_back('{data: model_mem[widx(addr, b)], last: (b == 3)});
    endtask

    // Refill beats are compared against the scoreboard as they appear.
    always @(negedge clk) begin
        if (rd_valid_s) begin
            if (sb.size() == 0) check("rd_spurious", 32'd1, 32'd0);
            else begin
                mon_e = sb.pop_front();
                check("rd_data", rd_data_s, mon_e.data);
                check("rd_last", {31'd0, rd_last_s}, {31'd0, mon_e.last});
            end
        end else if (rd_data_s != 32'd0) begin
            check("rd_data_idle", rd_data_s, 32'd0);
        end
    end

    // Returns at the negedge before the accepting edge, req_valid still high.
    task automatic request(input logic [31:0] addr, input logic we);
        int budget = 50;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        while (!req_ready_s && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!req_ready_s) check("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, input string tag);
        logic [31:0] vpat, lpat, rpat;
        vpat = '0; lpat = '0; rpat = '0;
        request(addr, 1'b0);
        push_read(addr);
        for (int k = 1; k <= lat + 5; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            vpat[k-1] = rd_valid_s;
            lpat[k-1] = rd_last_s;
            rpat[k-1] = req_ready_s;
        end
        check({tag, "_valid"}, vpat, 32'hF << lat);
        check({tag, "_last"},  lpat, 32'h1 << (lat + 3));
        check({tag, "_ready"}, rpat, 32'h1 << (lat + 4));
        check({tag, "_sb"}, sb.size(), 32'd0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] d0,
                            input int gap, input string tag);
        logic [31:0] wpat;
        int b = 0;
        int k = 0;
        int gap_left = 0;
        wpat = '0;
        request(addr, 1'b1);
        while (b < 4 && k < 40) begin
            @(negedge clk);
            k++;
            if (k == 1) req_valid = 1'b0;
            if (k <= 32) wpat[k-1] = wr_ready_s;
            if (gap_left > 0) begin
                wr_valid = 1'b0;
                check({tag, "_gap"}, {29'd0, busy_s, wr_ready_s, req_ready_s}, 32'b110);
                gap_left--;
            end else begin
                wr_valid = 1'b1;
                wr_data  = d0 + b;
                if (wr_ready_s) begin
                    model_mem[widx(addr, b)] = d0 + b;
                    b++;
                    if (b == 2) gap_left = gap;
                end
            end
        end
        check({tag, "_beats"}, b, 32'd4);
        @(negedge clk);
        k++;
        wr_valid = 1'b0;
        if (k <= 32) wpat[k-1] = wr_ready_s;
        check({tag, "_idle"}, {29'd0, req_ready_s, wr_ready_s, busy_s}, 32'b100);
        if (gap == 0) check({tag, "_wr_ready"}, wpat, 32'hF << lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rp, bp;
        for (int i = 0; i < 4096; i++) model_mem[i] = '0;
        sel = 1'b0; lat = 4;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        wr_valid = 1'b0; wr_data = '0;

        repeat (3) @(negedge clk);
        check("rst_outputs", {27'd0, req_ready_s, rd_valid_s, rd_last_s, wr_ready_s, busy_s}, 32'd0);
        check("rst_rd_data", rd_data_s, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {30'd0, req_ready_s, busy_s}, 32'b10);

        do_write(32'h100, 32'hA0, 0, "wr100");
        do_read(32'h100, "rd100");
        do_read(32'h10C, "rd10c");

        do_write(32'h200, 32'hB0, 2, "wr200");
        do_read(32'h200, "rd200");

        // Abandon a refill after its second beat.
        request(32'h100, 1'b0);
        push_read(32'h100);
        for (int k = 1; k <= lat + 2; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
        end
        #1 rst = 1'b1;
        @(negedge clk);
        check("rstmid_out", {29'd0, rd_valid_s, req_ready_s, busy_s}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_ready", {31'd0, req_ready_s}, 32'd1);
        do_read(32'h100, "rd100_again");

        do_write(32'h4020, 32'h11, 0, "wrwrap");
        do_read(32'h0020, "rdwrap");
        do_read(32'h0000, "rdline0");

        // Switch observation to the zero-latency instance.
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sel = 1'b1;
        lat = 0;
        @(negedge clk);
        do_write(32'h300, 32'h30, 0, "wr300");

        rp = '0; bp = '0;
        request(32'h300, 1'b0);
        push_read(32'h300);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            rp[k-1]  = req_ready_s;
            bp[k-1]  = busy_s;
            wr_valid = k[0];
            wr_data  = 32'hDEAD_0000 + k;
            if (k == 5) push_read(32'h300);
        end
        check("b2b_ready1", rp, 32'b10000);
        check("b2b_busy1",  bp, 32'b01111);
        rp = '0; bp = '0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            rp[k-1]  = req_ready_s;
            bp[k-1]  = busy_s;
            wr_valid = k[0];
            wr_data  = 32'hBEEF_0000 + k;
        end
        wr_valid = 1'b0;
        check("b2b_ready2", rp, 32'b10000);
        check("b2b_busy2",  bp, 32'b01111);
        do_read(32'h300, "rd300");

        repeat (2) @(negedge clk);
        check("sb_final", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/line_mem_responder.md
# line_mem_responder

Backing main-memory model that sits on the far side of the data cache's line-refill and writeback path, serving whole 16-byte lines as 4-word bursts. It accepts one line request at a time through a valid/ready handshake and waits a programmable access latency. It then either streams 4 read beats to the cache or absorbs 4 write beats from it. It gives the cache controller a realistic multi-cycle memory to stall against, replacing the single-cycle word memory on the miss path.

## Interface
- ADDR_WIDTH, 12, word-address bits of storage (depth = 2^ADDR_WIDTH words, 16 KiB default)
- LATENCY, 4, wait cycles between request acceptance and first data beat (0 allowed)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  line request present
- req_ready  out  1  responder idle, can accept a request
- req_we  in  1  1 = writeback (cache→mem), 0 = refill (mem→cache)
- req_addr  in  32  byte address; bits [3:0] ignored (line-aligned)
- wr_data  in  32  writeback beat data
- wr_valid  in  1  writeback beat present
- wr_ready  out  1  responder accepting writeback beats
- rd_data  out  32  refill beat data
- rd_valid  out  1  refill beat valid
- rd_last  out  1  marks 4th refill beat
- busy  out  1  request in progress (state ≠ S_IDLE)

## Operation
- Storage: word array mem[0 : 2^ADDR_WIDTH-1], zero at elaboration, never cleared by rst.
- Line base word index = {req_addr[ADDR_WIDTH+1:4], 2'b00}. Upper address bits are dropped, so addresses wrap modulo depth.
- Beat word index = base + beat, beat ∈ 0..3. Beats run in ascending order and never wrap into the next line.
- States:
  - S_IDLE
    - req_ready=1.
    - On req_valid: latch base and req_we, clear beat.
    - Go to S_LAT (LATENCY>0), or else to S_READ/S_WRITE per req_we.
  - S_LAT
    - Latency counter runs LATENCY cycles.
    - Then go to S_READ if !we, S_WRITE if we.
  - S_READ
    - rd_valid=1, rd_data=mem[base+beat], beat++ every cycle.
    - No backpressure: the consumer must take every beat.
    - rd_last=1 when beat==3. After beat 3, go to S_IDLE.
  - S_WRITE
    - wr_ready=1.
    - Each cycle with wr_valid: mem[base+beat] ← wr_data, beat++.
    - Cycles without wr_valid hold beat, indefinitely.
    - After beat 3 is written, go to S_IDLE.
- req_valid outside S_IDLE is ignored, not queued. wr_valid outside S_WRITE is ignored: no write, no count.
- req_we, req_addr are sampled only at acceptance. Later changes have no effect.
- rd_data = 0 whenever rd_valid=0.

## Timing
- Reset:
  - rst sampled high → state S_IDLE, beat=0, latency counter=0.
  - Memory contents are preserved.
  - While rst high, all outputs are 0, including req_ready.
  - The first cycle after rst deasserts has req_ready=1.
- Reset mid-burst: the burst is abandoned. Write beats already committed remain; no further beats.
- Acceptance edge E0 (req_valid & req_ready), read, LATENCY=L:
  - S_LAT covers the L cycles after E0.
  - Beats 0..3 appear in cycles L+1..L+4 after E0.
  - req_ready is high again in cycle L+5.
- Write with continuous wr_valid: same cycle positions for the beats; wr_ready high only during S_WRITE.
- A read immediately following a write to the same line returns the new data. Writes commit on the edge of the accepting beat.
- Minimum request-to-request spacing: L+5 cycles. busy is the exact complement of req_ready outside reset.

## Test plan
- Write/read back: LATENCY=4.
  - Write burst to 0x100 with data 0xA0..0xA3, wr_valid held high.
  - Then read 0x100.
  - Required: rd_valid in cycles 5–8 after acceptance, data 0xA0,0xA1,0xA2,0xA3, rd_last only on 0xA3, req_ready high in cycle 9.
- Offset ignored: read at 0x10C after the above.
  - Required: identical 4 beats starting at 0xA0.
- Write gaps: writeback to 0x200 with wr_valid low for 2 cycles between beats 1 and 2.
  - Required: wr_ready stays high, beat count holds, S_IDLE only after the 4th beat.
  - Read-back gives all 4 words correct.
- Back-to-back: req_valid held high with two reads queued by the driver, LATENCY=0.
  - Required: second acceptance exactly 5 cycles after the first; req_ready low and busy high in between.
  - wr_valid pulses during the read are ignored: the memory is unchanged.
- Reset mid-read: rst asserted after beat 1 of a read of 0x100.
  - Required: rd_valid=0 and req_ready=0 during reset, req_ready=1 in the next cycle.
  - A re-read returns 0xA0..0xA3 intact.
- Address wrap: ADDR_WIDTH=12, write 0x11..0x14 at 0x4020, read 0x0020.
  - Required: 0x11..0x14. The 0x0 line is unaffected.
